// File: rtl/clk_meter_pkg.sv
// Shared types and widths for the clock observation blocks.
package clk_meter_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizer chain for an asynchronous level plus a rising-edge pulse.
// The pulse is combinational from the last two flops and lasts one clk cycle.
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;

endmodule

// File: rtl/clock_ratio_meter.sv
// Measures period (and optionally high time) of a slow input in clk cycles.
// Define CLK_METER_DUTY_EN to build the high-time counter; otherwise o_high is 0.
//
// state   | meaning
// IDLE    | disabled; counters, match and lock cleared
// ARM     | waiting for the first rising edge to start a period
// MEASURE | counting; each rising edge closes a period and reports it
module clock_ratio_meter
  import clk_meter_pkg::*;
#(
  parameter int               SYNC_STAGES = 2,
  parameter logic [CNT_W-1:0] TIMEOUT     = 16'hFFFF,
  parameter int               LOCK_COUNT  = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sclk,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic             o_valid,
  output logic             o_lock,
  output logic             o_timeout
);

  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_COUNT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, arm_cnt_q, arm_cnt_d, match_q, match_d;
  logic [CNT_W-1:0] period_d, new_match;
  logic             valid_d, lock_d, timeout_d;
  logic             level, rise;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (i_clk),
    .rst   (i_rst),
    .din   (i_sclk),
    .level (level),
    .rise  (rise)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    arm_cnt_d = arm_cnt_q;
    match_d   = match_q;
    period_d  = o_period;
    valid_d   = 1'b0;
    lock_d    = o_lock;
    timeout_d = o_timeout;
    // match_q == 0 means no previous period to compare against
    new_match = 16'd1;
    if (match_q != '0 && cnt_q == o_period)
      new_match = (match_q >= LOCK_MAX) ? LOCK_MAX : match_q + 1'b1;

    if (!i_en) begin
      state_d   = IDLE;
      cnt_d     = '0;
      arm_cnt_d = '0;
      match_d   = '0;
      lock_d    = 1'b0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = ARM;
          arm_cnt_d = '0;
        end
        ARM: begin
          if (rise) begin
            cnt_d   = 16'd1;
            state_d = MEASURE;
          end else if (arm_cnt_q >= TIMEOUT) begin
            timeout_d = 1'b1;
            lock_d    = 1'b0;
            match_d   = '0;
            arm_cnt_d = '0;
          end else begin
            arm_cnt_d = arm_cnt_q + 1'b1;
          end
        end
        MEASURE: begin
          // an edge landing on the timeout cycle still completes the period
          if (rise) begin
            period_d = cnt_q;
            valid_d  = 1'b1;
            cnt_d    = 16'd1;
            match_d  = new_match;
            lock_d   = (new_match >= LOCK_MAX);
          end else if (cnt_q >= TIMEOUT) begin
            timeout_d = 1'b1;
            lock_d    = 1'b0;
            match_d   = '0;
            arm_cnt_d = '0;
            state_d   = ARM;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      arm_cnt_q <= '0;
      match_q   <= '0;
      o_period  <= '0;
      o_valid   <= 1'b0;
      o_lock    <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      arm_cnt_q <= arm_cnt_d;
      match_q   <= match_d;
      o_period  <= period_d;
      o_valid   <= valid_d;
      o_lock    <= lock_d;
      o_timeout <= timeout_d;
    end
  end

`ifdef CLK_METER_DUTY_EN
  logic [CNT_W-1:0] hcnt_q, hcnt_d, high_q;

  always_comb begin
    hcnt_d = hcnt_q;
    if (i_en && state_q != IDLE && rise)
      hcnt_d = 16'd1;
    else if (i_en && state_q == MEASURE && level && hcnt_q != '1)
      hcnt_d = hcnt_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      hcnt_q <= '0;
      high_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      if (valid_d)
        high_q <= hcnt_q;
    end
  end

  assign o_high = high_q;
`else
  logic unused_level;
  assign unused_level = level;
  assign o_high       = '0;
`endif

endmodule

// File: tb/tb_clock_ratio_meter.sv
// Directed bench for clock_ratio_meter (SYNC_STAGES=2, TIMEOUT=100, LOCK_COUNT=2).
module tb_clock_ratio_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sclk = 1'b0;
  logic        en = 1'b1;
  logic [15:0] period, high;
  logic        valid, lock, timeout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_valid = 0;

  typedef struct {
    int   period;
    int   high;
    logic lock;
    int   gap;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int   hi;
    int   lo;
    int   reps;
    int   exp_period;
    int   exp_high;
    logic exp_lock;
  } vec_t;
  vec_t vecs[6];

  clock_ratio_meter #(
    .SYNC_STAGES (2),
    .TIMEOUT     (16'd100),
    .LOCK_COUNT  (2)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_sclk    (sclk),
    .i_en      (en),
    .o_period  (period),
    .o_high    (high),
    .o_valid   (valid),
    .o_lock    (lock),
    .o_timeout (timeout)
  );

  always #5 clk = ~clk;

  function automatic int duty(input int h);
`ifdef CLK_METER_DUTY_EN
    return h;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input int p, input int h, input logic l, input int g);
    exp_t e;
    e.period = p;
    e.high   = duty(h);
    e.lock   = l;
    e.gap    = g;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", int'(valid), 0);
      end else begin
        e = exp_q.pop_front();
        check("period", int'(period), e.period);
        check("high", int'(high), e.high);
        check("lock_at_valid", int'(lock), int'(e.lock));
        if (e.gap != 0)
          check("valid_gap", cyc - last_valid, e.gap);
      end
      last_valid = cyc;
    end
  endtask

  task automatic level_for(input logic v, input int n);
    sclk = v;
    repeat (n) tick();
  endtask

  task automatic one_period(input int hi, input int lo);
    level_for(1'b1, hi);
    level_for(1'b0, lo);
  endtask

  task automatic reset_seq();
    sclk = 1'b0;
    en   = 1'b1;
    rst  = 1'b0;
    tick();
    rst  = 1'b1;
    level_for(1'b0, 3);
  endtask

  task automatic check_pending(input string name);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    vecs[0] = '{hi: 3,  lo: 2,  reps: 3, exp_period: 5,   exp_high: 3,  exp_lock: 1'b1};
    vecs[1] = '{hi: 1,  lo: 1,  reps: 3, exp_period: 2,   exp_high: 1,  exp_lock: 1'b1};
    vecs[2] = '{hi: 4,  lo: 3,  reps: 2, exp_period: 7,   exp_high: 4,  exp_lock: 1'b1};
    vecs[3] = '{hi: 1,  lo: 4,  reps: 1, exp_period: 5,   exp_high: 1,  exp_lock: 1'b0};
    vecs[4] = '{hi: 6,  lo: 5,  reps: 2, exp_period: 11,  exp_high: 6,  exp_lock: 1'b1};
    vecs[5] = '{hi: 50, lo: 50, reps: 2, exp_period: 100, exp_high: 50, exp_lock: 1'b1};

    // reset values
    rst = 1'b0;
    tick();
    tick();
    check("rst_period", int'(period), 0);
    check("rst_high", int'(high), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_lock", int'(lock), 0);
    check("rst_timeout", int'(timeout), 0);
    rst = 1'b1;

    // latency: valid on the 3rd edge after the closing edge is first sampled
    reset_seq();
    one_period(3, 2);
    push_exp(5, 3, 1'b0, 0);
    sclk = 1'b1;
    tick();
    check("latency_e1", int'(valid), 0);
    tick();
    check("latency_e2", int'(valid), 0);
    tick();
    check("latency_e3", int'(valid), 1);
    level_for(1'b0, 2);
    check_pending("latency_pending");

    // steady-period table; the 100-cycle row lands its edge on the timeout cycle
    for (int v = 0; v < 6; v++) begin
      reset_seq();
      for (int p = 0; p < vecs[v].reps; p++)
        push_exp(vecs[v].exp_period, vecs[v].exp_high, (p >= 1), (p >= 1) ? vecs[v].exp_period : 0);
      for (int p = 0; p < vecs[v].reps; p++)
        one_period(vecs[v].hi, vecs[v].lo);
      level_for(1'b1, 4);
      level_for(1'b0, 2);
      check_pending("table_pending");
      check("table_final_lock", int'(lock), int'(vecs[v].exp_lock));
      check("table_timeout", int'(timeout), 0);
    end

    // divide-by-7 then divide-by-9
    reset_seq();
    push_exp(7, 4, 1'b0, 0);
    push_exp(7, 4, 1'b1, 7);
    push_exp(7, 4, 1'b1, 7);
    push_exp(9, 5, 1'b0, 9);
    push_exp(9, 5, 1'b1, 9);
    repeat (3) one_period(4, 3);
    repeat (2) one_period(5, 4);
    level_for(1'b1, 4);
    level_for(1'b0, 2);
    check_pending("switch_pending");

    // timeout after lock, then restart
    reset_seq();
    push_exp(5, 3, 1'b0, 0);
    push_exp(5, 3, 1'b1, 5);
    push_exp(5, 3, 1'b1, 5);
    repeat (3) one_period(3, 2);
    level_for(1'b1, 3);
    sclk = 1'b0;
    n = 0;
    while (!timeout && n < 300) begin
      tick();
      n++;
    end
    check("timeout_seen", int'(timeout), 1);
    check("timeout_delay", cyc - last_valid, 100);
    check("timeout_lock", int'(lock), 0);
    check_pending("timeout_pending");
    push_exp(5, 3, 1'b0, 0);
    one_period(3, 2);
    level_for(1'b1, 3);
    level_for(1'b0, 2);
    check_pending("restart_pending");
    check("timeout_sticky", int'(timeout), 1);

    // one-cycle reset mid-period at divide-by-11
    reset_seq();
    push_exp(11, 6, 1'b0, 0);
    push_exp(11, 6, 1'b1, 11);
    repeat (2) one_period(6, 5);
    level_for(1'b1, 6);
    level_for(1'b0, 2);
    check_pending("prereset_pending");
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midrst_period", int'(period), 0);
    check("midrst_high", int'(high), 0);
    check("midrst_valid", int'(valid), 0);
    check("midrst_lock", int'(lock), 0);
    check("midrst_timeout", int'(timeout), 0);
    push_exp(11, 6, 1'b0, 0);
    level_for(1'b0, 3);
    one_period(6, 5);
    level_for(1'b1, 4);
    level_for(1'b0, 2);
    check_pending("postreset_pending");

    // enable dropped for 3 cycles mid-period
    reset_seq();
    push_exp(9, 5, 1'b0, 0);
    push_exp(9, 5, 1'b1, 9);
    repeat (2) one_period(5, 4);
    level_for(1'b1, 5);
    sclk = 1'b0;
    en = 1'b0;
    repeat (3) tick();
    check("en_drop_lock", int'(lock), 0);
    check("en_drop_period_hold", int'(period), 9);
    check_pending("en_drop_pending");
    en = 1'b1;
    tick();
    push_exp(7, 4, 1'b0, 0);
    push_exp(7, 4, 1'b1, 7);
    push_exp(7, 4, 1'b1, 7);
    repeat (3) one_period(4, 3);
    level_for(1'b1, 4);
    level_for(1'b0, 2);
    check_pending("en_restore_pending");
    check("en_restore_lock", int'(lock), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
